// File: rtl/unidade_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// unidade_controle_multiciclo
//
// Multi-cycle control unit for the single-cycle RISC-V datapath
// (parte_operativa). It decodes opcode/funct3/funct7 into the datapath control
// bus. A 3-state sequencer (FETCH -> EXEC -> WB) makes every architectural
// write (PC, register file, data memory) happen on exactly one clock edge per
// instruction. Unsupported encodings and ECALL park the unit in a halt state.
//
// Supported instructions: ADD, SUB, ADDI, LW, SW, ECALL (clean halt).
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; returns to FETCH, clears status
//                and counters
//   run          level enable, sampled only in FETCH
//   opcode       instruction[6:0]
//   funct3       instruction[14:12]
//   funct7       instruction[31:25]
//   PCWrite      PC update enable (WB only)
//   MemWrite     data memory write enable (WB only, SW)
//   RegWrite     register file write enable (WB only, ADD/SUB/ADDI/LW)
//   ALUSrc       0 = rs2, 1 = immediate (combinational decode)
//   ResultSrc    00 = ALU, 01 = memory (combinational decode)
//   ALUControl   0000 = ADD, 0001 = SUB (combinational decode)
//   halted       sticky, set when the halt state is entered
//   illegal      sticky, set when the halt came from an unsupported encoding
//   instr_count  retired instruction count
//   cycle_count  cycles spent outside the halt state
//
// Configuration
//   CTRL_PERF_COUNTERS_EN  when defined, instr_count/cycle_count are real
//                          32-bit wrapping counters; otherwise both outputs
//                          are tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module unidade_controle_multiciclo (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic [1:0]  ResultSrc,
    output logic [3:0]  ALUControl,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [1:0] RES_ALU   = 2'b00;
    localparam logic [1:0] RES_MEM   = 2'b01;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_WB    = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t state;
    state_t state_next;

    // Decode results, independent of the sequencer state.
    logic dec_legal;      // supported, non-halting instruction
    logic dec_ecall;      // clean halt request
    logic dec_reg_write;  // instruction writes rd
    logic dec_mem_write;  // instruction writes data memory

    // ------------------------------------------------------------------
    // Instruction decode. Anything not matched leaves dec_legal at 0 and
    // the datapath controls at their neutral ADD/rs2/ALU values.
    // ------------------------------------------------------------------
    always_comb begin
        dec_legal     = 1'b0;
        dec_ecall     = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_write = 1'b0;
        ALUSrc        = 1'b0;
        ResultSrc     = RES_ALU;
        ALUControl    = ALU_ADD;

        case (opcode)
            OP_RTYPE: begin
                if (funct3 == F3_ADD) begin
                    if (funct7 == F7_ADD) begin
                        dec_legal     = 1'b1;
                        dec_reg_write = 1'b1;
                    end else if (funct7 == F7_SUB) begin
                        dec_legal     = 1'b1;
                        dec_reg_write = 1'b1;
                        ALUControl    = ALU_SUB;
                    end
                end
            end
            OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    dec_legal     = 1'b1;
                    dec_reg_write = 1'b1;
                    ALUSrc        = 1'b1;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_WORD) begin
                    dec_legal     = 1'b1;
                    dec_reg_write = 1'b1;
                    ALUSrc        = 1'b1;
                    ResultSrc     = RES_MEM;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_WORD) begin
                    dec_legal     = 1'b1;
                    dec_mem_write = 1'b1;
                    ALUSrc        = 1'b1;
                end
            end
            OP_SYSTEM: begin
                // Only the rest of the word beyond funct3 is ignored here,
                // so any SYSTEM/000 encoding is treated as a clean stop.
                if (funct3 == F3_ADD) begin
                    dec_ecall = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer state register. Because the write enables are decoded
    // from this register, an asynchronous reset drops them immediately.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and write-enable logic. Enables exist only in WB so PC,
    // register file and memory commit together on the edge leaving WB.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;

        case (state)
            S_FETCH: begin
                if (run) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                // Illegal and ECALL never reach WB, so they cannot write
                // anything nor advance the PC.
                if (dec_legal) begin
                    state_next = S_WB;
                end else begin
                    state_next = S_HALT;
                end
            end
            S_WB: begin
                PCWrite    = 1'b1;
                RegWrite   = dec_reg_write;
                MemWrite   = dec_mem_write;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky halt status, captured on the edge that enters HALT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else if (state == S_EXEC && !dec_legal) begin
            halted  <= 1'b1;
            illegal <= !dec_ecall;
        end
    end

`ifdef CTRL_PERF_COUNTERS_EN
    // ------------------------------------------------------------------
    // Performance counters. Both wrap silently and freeze in HALT; stalled
    // FETCH cycles count towards cycle_count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= 32'h0;
            cycle_count <= 32'h0;
        end else begin
            if (state != S_HALT) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (state == S_WB) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end
`else
    assign instr_count = 32'h0;
    assign cycle_count = 32'h0;
`endif

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle_multiciclo
//
// Self-checking bench for unidade_controle_multiciclo. A directed prologue
// walks through the instruction sequences of interest, then a randomized run
// mixes instruction kinds, run stalls, halts and asynchronous resets. Expected
// outputs come from an instruction-level reference model: it classifies the
// instruction word, tracks how many cycles the accepted instruction has been
// in flight, and counts retired instructions and non-halted cycles.
// -----------------------------------------------------------------------------
module tb_unidade_controle_multiciclo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [31:0] instr = 32'h0000_0013;

    logic        PCWrite, MemWrite, RegWrite, ALUSrc, halted, illegal;
    logic [1:0]  ResultSrc;
    logic [3:0]  ALUControl;
    logic [31:0] instr_count, cycle_count;

    unidade_controle_multiciclo dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .opcode      (instr[6:0]),
        .funct3      (instr[14:12]),
        .funct7      (instr[31:25]),
        .PCWrite     (PCWrite),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .ALUSrc      (ALUSrc),
        .ResultSrc   (ResultSrc),
        .ALUControl  (ALUControl),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {K_ADD, K_SUB, K_ADDI, K_LW, K_SW, K_ECALL, K_ILL} kind_t;

    function automatic kind_t ref_kind(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0000000) return K_ADD;
        if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0100000) return K_SUB;
        if (op == 7'b0010011 && f3 == 3'b000) return K_ADDI;
        if (op == 7'b0000011 && f3 == 3'b010) return K_LW;
        if (op == 7'b0100011 && f3 == 3'b010) return K_SW;
        if (op == 7'b1110011 && f3 == 3'b000) return K_ECALL;
        return K_ILL;
    endfunction

    // in_flight: an instruction has been accepted; age: cycles since it was
    // accepted (1 = executing, 2 = commit cycle).
    bit          in_flight_m;
    int          age_m;
    bit          halted_m, illegal_m;
    logic [31:0] instr_m, cycle_m;

    task automatic model_reset();
        in_flight_m = 0;
        age_m       = 0;
        halted_m    = 0;
        illegal_m   = 0;
        instr_m     = 0;
        cycle_m     = 0;
    endtask

    // Advance the model across one rising edge using the inputs present at it.
    task automatic model_edge();
        kind_t k;
        k = ref_kind(instr);
        if (reset) begin
            model_reset();
        end else if (!halted_m) begin
            cycle_m = cycle_m + 1;
            if (!in_flight_m) begin
                if (run) begin
                    in_flight_m = 1;
                    age_m       = 1;
                end
            end else if (age_m == 1) begin
                if (k == K_ECALL || k == K_ILL) begin
                    halted_m    = 1;
                    illegal_m   = (k == K_ILL);
                    in_flight_m = 0;
                    age_m       = 0;
                end else begin
                    age_m = 2;
                end
            end else begin
                instr_m     = instr_m + 1;
                in_flight_m = 0;
                age_m       = 0;
            end
        end
    endtask

    task automatic check_all();
        kind_t k;
        bit    commit;
        k      = ref_kind(instr);
        commit = in_flight_m && age_m == 2;
        chk("PCWrite",    32'(PCWrite),  32'(commit));
        chk("RegWrite",   32'(RegWrite), 32'(commit && (k == K_ADD || k == K_SUB || k == K_ADDI || k == K_LW)));
        chk("MemWrite",   32'(MemWrite), 32'(commit && k == K_SW));
        chk("ALUSrc",     32'(ALUSrc),   32'(k == K_ADDI || k == K_LW || k == K_SW));
        chk("ResultSrc",  32'(ResultSrc), (k == K_LW) ? 32'd1 : 32'd0);
        chk("ALUControl", 32'(ALUControl), (k == K_SUB) ? 32'd1 : 32'd0);
        chk("halted",     32'(halted),   32'(halted_m));
        chk("illegal",    32'(illegal),  32'(illegal_m));
`ifdef CTRL_PERF_COUNTERS_EN
        chk("instr_count", instr_count, instr_m);
        chk("cycle_count", cycle_count, cycle_m);
`else
        chk("instr_count", instr_count, 32'h0);
        chk("cycle_count", cycle_count, 32'h0);
`endif
    endtask

    // One clock cycle: model crosses the edge, new inputs are applied shortly
    // after it (reset acts asynchronously), outputs checked mid-cycle.
    task automatic step(input logic [31:0] i, input logic r, input logic rs);
        @(posedge clk);
        model_edge();
        #1;
        instr = i;
        run   = r;
        reset = rs;
        if (rs) model_reset();
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel;
        w   = $urandom;
        sel = $urandom_range(0, 19);
        case (sel)
            0, 1, 2:   begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = 7'b0000000; end
            3, 4, 5:   begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = 7'b0100000; end
            6, 7, 8:   begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; end
            9, 10, 11: begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
            12, 13, 14: begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
            15:        begin w = 32'h0000_0073; end
            16:        begin w[6:0] = 7'b1111111; end
            17:        begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = 7'b0000001; end
            18:        begin w[6:0] = 7'b0000011; w[14:12] = 3'b000; end
            default:   ;
        endcase
        return w;
    endfunction

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_ADD  = 32'h0020_81B3;
    localparam logic [31:0] I_SUB  = 32'h4020_81B3;
    localparam logic [31:0] I_SW   = 32'h0030_2623;
    localparam logic [31:0] I_LW   = 32'h00C0_2203;
    localparam logic [31:0] I_BAD  = 32'h0000_007F;
    localparam logic [31:0] I_ECL  = 32'h0000_0073;

    initial begin
        logic [31:0] nxt_i;
        logic        nxt_run, nxt_rst;
        int          halt_wait;

        model_reset();
        // Reset state, decode follows inputs while reset is held.
        step(I_ADDI, 1'b1, 1'b1);
        step(I_ADDI, 1'b1, 1'b1);

        // ADDI, ADD, SUB, SW, LW back to back with run held high.
        step(I_ADDI, 1'b1, 1'b0);
        repeat (3) step(I_ADDI, 1'b1, 1'b0);
        repeat (3) step(I_ADD,  1'b1, 1'b0);
        repeat (3) step(I_SUB,  1'b1, 1'b0);
        repeat (3) step(I_SW,   1'b1, 1'b0);
        repeat (3) step(I_LW,   1'b1, 1'b0);

        // Illegal opcode from reset: halts after two edges, then stays.
        step(I_BAD, 1'b1, 1'b1);
        repeat (5) step(I_BAD, 1'b1, 1'b0);

        // ECALL: clean halt.
        step(I_ECL, 1'b1, 1'b1);
        repeat (4) step(I_ECL, 1'b1, 1'b0);

        // Stall in FETCH for 5 cycles, then run.
        step(I_ADD, 1'b0, 1'b1);
        step(I_ADD, 1'b0, 1'b0);
        repeat (5) step(I_ADD, 1'b0, 1'b0);
        repeat (4) step(I_ADD, 1'b1, 1'b0);

        // Drop run during EXEC/WB: instruction still completes.
        step(I_LW, 1'b1, 1'b0);
        repeat (4) step(I_LW, 1'b0, 1'b0);

        // Reset during WB, then normal sequencing.
        for (int n = 0; n < 10 && !(in_flight_m && age_m == 2); n++) begin
            step(I_SUB, 1'b1, 1'b0);
        end
        chk("reached_wb", 32'(in_flight_m && age_m == 2), 32'd1);
        step(I_SUB, 1'b1, 1'b1);
        repeat (7) step(I_SUB, 1'b1, 1'b0);

        // Randomized traffic.
        halt_wait = 0;
        for (int c = 0; c < 4000; c++) begin
            nxt_i   = in_flight_m ? instr : rand_instr();
            nxt_run = ($urandom_range(0, 7) != 0);
            nxt_rst = ($urandom_range(0, 149) == 0);
            if (halted_m) begin
                halt_wait++;
                if (halt_wait > 3) nxt_rst = 1'b1;
            end else begin
                halt_wait = 0;
            end
            step(nxt_i, nxt_run, nxt_rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle_multiciclo.md
# unidade_controle_multiciclo

Sequenced control unit sitting directly upstream of the single-cycle RISC-V datapath (`parte_operativa`). It decodes `opcode`/`funct3`/`funct7` into the datapath control bus and runs a 3-state FSM so that every architectural write (register file, data memory, PC) happens on exactly one clock edge per instruction. It also detects unsupported instructions and halts, and can optionally expose performance counters.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces FSM to `S_FETCH` and clears all counters.
- `run`  in  1  level enable, sampled only in `S_FETCH`; 0 stalls before the next instruction starts.
- `opcode`  in  7  instruction[6:0] from the datapath.
- `funct3`  in  3  instruction[14:12].
- `funct7`  in  7  instruction[31:25].
- `PCWrite`  out  1  PC update enable.
- `MemWrite`  out  1  data memory write enable.
- `RegWrite`  out  1  register file write enable.
- `ALUSrc`  out  1  0 = rs2, 1 = immediate.
- `ResultSrc`  out  2  00 = ALU, 01 = memory.
- `ALUControl`  out  4  0000 = ADD, 0001 = SUB.
- `halted`  out  1  sticky; 1 in `S_HALT`.
- `illegal`  out  1  sticky; 1 if the halt was caused by an unsupported encoding (0 for ECALL).
- `instr_count`  out  32  retired instructions (see Configuration).
- `cycle_count`  out  32  cycles spent outside `S_HALT` (see Configuration).

## Operation
- Supported decode, all others illegal:
  - R-type 0110011, funct3 000: funct7 0000000 gives ADD; funct7 0100000 gives SUB. Both use ALUSrc=0, ResultSrc=00, and are register writes.
  - ADDI 0010011, funct3 000: ADD, ALUSrc=1, ResultSrc=00, register write.
  - LW 0000011, funct3 010: ADD, ALUSrc=1, ResultSrc=01, register write.
  - SW 0100011, funct3 010: ADD, ALUSrc=1, memory write.
  - ECALL 1110011 with funct3 000: clean halt, `illegal` stays 0.
- `ALUSrc`, `ResultSrc` and `ALUControl` are combinational from the decode in every state. For illegal or ECALL encodings they are 0/00/0000.
- FSM states, 2-bit encoding:
  - `S_FETCH` (00): instruction settles. Goes to `S_EXEC` if `run`=1, otherwise stays.
  - `S_EXEC` (01): ALU and memory read settle. Goes to `S_HALT` if the instruction is illegal or ECALL, otherwise to `S_WB`.
  - `S_WB` (10): commit. Goes to `S_FETCH`.
  - `S_HALT` (11): absorbing; only `reset` exits.
- Write enables are asserted only in `S_WB`:
  - `PCWrite` = 1 in `S_WB`.
  - `RegWrite` = 1 in `S_WB` for register-writing instructions.
  - `MemWrite` = 1 in `S_WB` for SW.
  - PC, register file and memory therefore all update on the same edge, while the instruction is still valid.
- `halted` and `illegal` are registered. They are set on the edge entering `S_HALT` and are cleared only by reset.
- Illegal or ECALL instructions never assert any write enable, and the PC is not advanced past them.

## Timing
- Reset values: state `S_FETCH`; `PCWrite`, `MemWrite`, `RegWrite`, `halted`, `illegal` all 0; both counters 0. Decode outputs follow the inputs.
- With `run`=1 throughout, each instruction takes exactly 3 cycles. The commit edge is the rising edge that ends `S_WB`, so the n-th instruction commits at the end of cycle 3n after reset release.
- The write-enable pulse is exactly 1 cycle wide.
- Halt: `halted` rises on the edge ending `S_EXEC` of the offending instruction, i.e. 2 cycles after its `S_FETCH` begins.
- `run` deasserted during `S_EXEC` or `S_WB` has no effect; the current instruction completes and the FSM then waits in `S_FETCH`.
- Reset asserted mid-`S_WB` drops all enables immediately (asynchronously), so no partial commit is guaranteed. The FSM restarts at `S_FETCH`.
- Counters wrap modulo 2^32 without flags.

## Configuration
- Macro: `CTRL_PERF_COUNTERS_EN`.
- Defined:
  - `instr_count` increments on each `S_WB` edge.
  - `cycle_count` increments every cycle not in `S_HALT`, including stalled `S_FETCH` cycles.
  - Both freeze in `S_HALT`.
- Undefined: both outputs are tied to 32'h0 and no counter flops are built. FSM behaviour is identical.

## Test plan
- Reset, `run`=1, feed ADDI 0x00500093 → `PCWrite`=`RegWrite`=1 only in cycle 3; ALUSrc=1, ResultSrc=00, ALUControl=0000; `MemWrite` stays 0.
- Feed ADD 0x002081B3, then SUB (funct7 0100000) → ALUControl 0000 then 0001, ALUSrc=0. RegWrite pulses in cycles 3 and 6; with the macro, `instr_count`=2 at cycle 6.
- Feed SW 0x00302623 then LW 0x00C02203 → `MemWrite` pulses only in cycle 3 with RegWrite=0. In cycle 6 RegWrite=1 with ResultSrc=01.
- Feed opcode 1111111 → `halted`=`illegal`=1 after the 2nd edge; no write enable ever asserted; `cycle_count` frozen at 2. ECALL 0x00000073 → `halted`=1, `illegal`=0.
- Hold `run`=0 for 5 cycles after reset → FSM stays in `S_FETCH`, no writes, `cycle_count`=5. Raise `run` → first commit exactly 3 cycles later.
- Assert `reset` during `S_WB` → `PCWrite`/`RegWrite` drop in the same cycle; after release, normal 3-cycle sequencing resumes with counters at 0.
